// File: rtl/fe_kp_pkg.sv
// Shared keypoint types for the feature-extraction back end (collector and descriptor stages).
package fe_kp_pkg;

    localparam int SCORE_WIDTH  = 8;
    localparam int IMAGE_WIDTH  = 640;
    localparam int IMAGE_HEIGHT = 480;
    localparam int X_W          = $clog2(IMAGE_WIDTH);
    localparam int Y_W          = $clog2(IMAGE_HEIGHT);

    typedef struct packed {
        logic [SCORE_WIDTH-1:0] score;
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
    } kp_t;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_COLLECT,
        KP_DRAIN
    } kp_state_e;

    function automatic int cnt_width(input int max_kp);
        return $clog2(max_kp + 1);
    endfunction

endpackage

// File: rtl/keypoint_collector_if.sv
// Frame control, NMS input strobe, output stream and per-frame status of the keypoint collector.
interface keypoint_collector_if #(
    parameter int MAX_KP = 500
);
    import fe_kp_pkg::*;

    localparam int CNT_W = cnt_width(MAX_KP);

    logic                   frame_start;
    logic                   frame_done;
    logic [SCORE_WIDTH-1:0] score_thresh;
    logic                   kp_in_valid;
    logic [SCORE_WIDTH-1:0] kp_in_score;
    logic [X_W-1:0]         kp_in_x;
    logic [Y_W-1:0]         kp_in_y;
    logic                   kp_out_valid;
    logic                   kp_out_ready;
    logic [SCORE_WIDTH-1:0] kp_out_score;
    logic [X_W-1:0]         kp_out_x;
    logic [Y_W-1:0]         kp_out_y;
    logic                   kp_out_last;
    logic                   kp_out_null;
    logic [CNT_W-1:0]       kp_count;
    logic                   overflow;
    logic                   protocol_err;
    logic                   busy;

    modport master (
        output frame_start, frame_done, score_thresh,
        output kp_in_valid, kp_in_score, kp_in_x, kp_in_y, kp_out_ready,
        input  kp_out_valid, kp_out_score, kp_out_x, kp_out_y, kp_out_last, kp_out_null,
        input  kp_count, overflow, protocol_err, busy
    );

    modport slave (
        input  frame_start, frame_done, score_thresh,
        input  kp_in_valid, kp_in_score, kp_in_x, kp_in_y, kp_out_ready,
        output kp_out_valid, kp_out_score, kp_out_x, kp_out_y, kp_out_last, kp_out_null,
        output kp_count, overflow, protocol_err, busy
    );

endinterface

// File: rtl/kp_sync_fifo.sv
// Synchronous keypoint FIFO; head is a registered read that always shows the oldest entry.
module kp_sync_fifo
    import fe_kp_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  kp_t                       push_data,
    input  logic                      pop,
    output kp_t                       head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);

    kp_t          mem [DEPTH];
    kp_t          head_reg;
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [AW:0]  rd_ptr_next;
    logic         pop_ok;
    logic         push_ok;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level       = wr_ptr_reg - rd_ptr_reg;
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop_ok);
    assign head        = head_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // The read address looks one pop ahead; a write to that same slot bypasses the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(push_ok);
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/keypoint_collector.sv
// Per-frame keypoint gatherer: threshold + budget filtering, buffering, and last/null beat framing.
module keypoint_collector
    import fe_kp_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_KP     = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    keypoint_collector_if.slave  bus
);
    localparam int CNT_W = cnt_width(MAX_KP);
    localparam int AW    = $clog2(FIFO_DEPTH);

    kp_state_e              state_reg;
    logic [SCORE_WIDTH-1:0] thresh_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   overflow_reg;
    logic                   perr_reg;

    kp_t         in_kp;
    kp_t         head;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        qualified;
    logic        room;
    logic        push;
    logic        drop;
    logic        pop;
    logic        out_valid;
    logic        out_last;
    logic        out_null;
    logic        fire;

    assign in_kp     = '{score: bus.kp_in_score, x: bus.kp_in_x, y: bus.kp_in_y};
    assign qualified = (state_reg == KP_COLLECT) && bus.kp_in_valid &&
                       (bus.kp_in_score >= thresh_reg);
    assign room      = (count_reg < CNT_W'(MAX_KP)) && (!full || pop);
    assign push      = qualified && room;
    assign drop      = qualified && !room;

    // DRAIN is left on the handshake of the last beat, so an empty FIFO in DRAIN
    // can only mean nothing was left to send: that is the null terminator.
    assign out_null  = (state_reg == KP_DRAIN) && empty;
    assign out_valid = !empty || (state_reg == KP_DRAIN);
    assign out_last  = (state_reg == KP_DRAIN) && (empty || (level == (AW+1)'(1)));
    assign fire      = out_valid && bus.kp_out_ready;
    assign pop       = fire && !empty;

    kp_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_kp),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= KP_IDLE;
            thresh_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            perr_reg     <= 1'b0;
        end else begin
            perr_reg <= bus.frame_start && (state_reg != KP_IDLE);
            case (state_reg)
                KP_IDLE: begin
                    if (bus.frame_start) begin
                        state_reg    <= KP_COLLECT;
                        thresh_reg   <= bus.score_thresh;
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                    end
                end
                KP_COLLECT: begin
                    if (bus.frame_done) begin
                        state_reg <= KP_DRAIN;
                    end
                end
                KP_DRAIN: begin
                    if (fire && out_last) begin
                        state_reg <= KP_IDLE;
                    end
                end
                default: state_reg <= KP_IDLE;
            endcase
            if (push) begin
                count_reg <= count_reg + CNT_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.kp_out_valid = out_valid;
    assign bus.kp_out_score = empty ? '0 : head.score;
    assign bus.kp_out_x     = empty ? '0 : head.x;
    assign bus.kp_out_y     = empty ? '0 : head.y;
    assign bus.kp_out_last  = out_last;
    assign bus.kp_out_null  = out_null;
    assign bus.kp_count     = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.protocol_err = perr_reg;
    assign bus.busy         = (state_reg != KP_IDLE);

endmodule
